// File: rtl/fp_mul_arb_pkg.sv
// Shared types and constants for the floating-point multiplier arbiter.
// Holds the FSM state encoding, the FP word width and the quiet-NaN pattern.
package fp_mul_arb_pkg;

  localparam int FP_W = 32;
  localparam logic [FP_W-1:0] NAN_QUIET = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    DELIVER
  } state_e;

  // Width of a requester index; at least one bit even for degenerate counts.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fp_mul_arbiter_if.sv
// Request/response and multiplier-driver bundle of fp_mul_arbiter.
// The arbiter takes the slave modport; the requesters and driver take the master side.
interface fp_mul_arbiter_if
  import fp_mul_arb_pkg::*;
#(
  parameter int N_REQ = 4
);

  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ-1:0]      req_ready;
  logic [N_REQ*FP_W-1:0] req_a;
  logic [N_REQ*FP_W-1:0] req_b;
  logic [N_REQ-1:0]      rsp_valid;
  logic [N_REQ-1:0]      rsp_ready;
  logic [N_REQ*FP_W-1:0] rsp_z;

  logic                  mul_start;
  logic [FP_W-1:0]       mul_a;
  logic [FP_W-1:0]       mul_b;
  logic                  mul_busy;
  logic                  mul_done;
  logic [FP_W-1:0]       mul_z;

  modport master (
    output req_valid, req_a, req_b, rsp_ready, mul_busy, mul_done, mul_z,
    input  req_ready, rsp_valid, rsp_z, mul_start, mul_a, mul_b
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, mul_busy, mul_done, mul_z,
    output req_ready, rsp_valid, rsp_z, mul_start, mul_a, mul_b
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible index after last_grant,
// wrapping from N_REQ-1 back to 0.
module rr_pick
  import fp_mul_arb_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int GW    = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] eligible,
  input  logic [GW-1:0]    last_grant,
  output logic             found,
  output logic [GW-1:0]    idx
);

  always_comb begin : search
    int cand;
    cand  = 0;
    found = 1'b0;
    idx   = '0;
    // k = N_REQ revisits last_grant itself, so a lone requester is never starved.
    for (int k = 1; k <= N_REQ; k++) begin
      cand = int'(last_grant) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!found && eligible[cand]) begin
        found = 1'b1;
        idx   = GW'(cand);
      end
    end
  end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Shares one floating-point multiplier driver among N_REQ requesters with
// round-robin selection, per-requester result holding and a completion timeout.
module fp_mul_arbiter
  import fp_mul_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  fp_mul_arbiter_if.slave bus,
  output logic            timeout_err,
  output logic [15:0]     op_count
);

  localparam int GW = idx_w(N_REQ);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  state_e                state_q, state_d;
  logic [GW-1:0]         last_grant_q, last_grant_d;
  logic [GW-1:0]         grant_q, grant_d;
  logic [FP_W-1:0]       mul_a_q, mul_a_d;
  logic [FP_W-1:0]       mul_b_q, mul_b_d;
  logic                  mul_start_q, mul_start_d;
  logic [N_REQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic [N_REQ*FP_W-1:0] rsp_z_q, rsp_z_d;
  logic [15:0]           op_count_q, op_count_d;
  logic                  timeout_err_q, timeout_err_d;
  logic [TW-1:0]         tmo_q, tmo_d;

  logic [N_REQ-1:0]      eligible;
  logic [N_REQ-1:0]      req_ready_c;
  logic                  found;
  logic [GW-1:0]         pick;
  logic                  deliver;
  logic [FP_W-1:0]       deliver_z;

  // A requester still holding an unconsumed result is skipped, not waited on.
  assign eligible = bus.req_valid & ~rsp_valid_q;

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .eligible  (eligible),
    .last_grant(last_grant_q),
    .found     (found),
    .idx       (pick)
  );

  always_comb begin
    // NOTE: every next-state value starts from its register, so no path leaves a latch.
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    grant_d       = grant_q;
    mul_a_d       = mul_a_q;
    mul_b_d       = mul_b_q;
    mul_start_d   = 1'b0;
    rsp_valid_d   = rsp_valid_q & ~bus.rsp_ready;
    rsp_z_d       = rsp_z_q;
    op_count_d    = op_count_q;
    timeout_err_d = timeout_err_q;
    tmo_d         = tmo_q;
    req_ready_c   = '0;
    deliver       = 1'b0;
    deliver_z     = '0;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          req_ready_c[pick] = 1'b1;
          mul_a_d           = bus.req_a[int'(pick)*FP_W +: FP_W];
          mul_b_d           = bus.req_b[int'(pick)*FP_W +: FP_W];
          grant_d           = pick;
          mul_start_d       = 1'b1;
          state_d           = ISSUE;
        end
      end
      ISSUE: begin
        tmo_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY, WAIT_DONE: begin
        tmo_d = tmo_q + 1'b1;
        // done is only trusted after busy has been seen, so a stale level is ignored.
        if (state_q == WAIT_DONE && bus.mul_done && !bus.mul_busy) begin
          deliver    = 1'b1;
          deliver_z  = bus.mul_z;
          op_count_d = op_count_q + 16'd1;
        end else if (tmo_q == TMO_LAST) begin
          deliver       = 1'b1;
          deliver_z     = NAN_QUIET;
          timeout_err_d = 1'b1;
        end else if (state_q == WAIT_BUSY && bus.mul_busy) begin
          state_d = WAIT_DONE;
        end
        if (deliver) begin
          rsp_z_d[int'(grant_q)*FP_W +: FP_W] = deliver_z;
          rsp_valid_d[grant_q]                = 1'b1;
          state_d                             = DELIVER;
        end
      end
      DELIVER: begin
        last_grant_d = grant_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_grant_q  <= GW'(N_REQ - 1);
      grant_q       <= '0;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      mul_start_q   <= 1'b0;
      rsp_valid_q   <= '0;
      rsp_z_q       <= '0;
      op_count_q    <= '0;
      timeout_err_q <= 1'b0;
      tmo_q         <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      grant_q       <= grant_d;
      mul_a_q       <= mul_a_d;
      mul_b_q       <= mul_b_d;
      mul_start_q   <= mul_start_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_z_q       <= rsp_z_d;
      op_count_q    <= op_count_d;
      timeout_err_q <= timeout_err_d;
      tmo_q         <= tmo_d;
    end
  end

  // The acceptance pulse is decoded from IDLE, so it is masked while reset is held.
  assign bus.req_ready = req_ready_c & {N_REQ{rst_n}};
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_z     = rsp_z_q;
  assign bus.mul_start = mul_start_q;
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign timeout_err   = timeout_err_q;
  assign op_count      = op_count_q;

endmodule

// File: doc/fp_mul_arbiter.md
FP_MUL_ARBITER -- requirements
Module: fp_mul_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters, 2..8.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 64: maximum cycles to wait for multiplier completion.
REQ-003 SHALL have port clk  input  1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  N_REQ: per-requester operand-pair valid.
REQ-006 SHALL have port req_a  input  N_REQ*32: requester i operand A in bits [32i+31:32i], IEEE-754 single.
REQ-007 SHALL have port req_b  input  N_REQ*32: requester i operand B, same packing.
REQ-008 SHALL have port req_ready  output  N_REQ: one-hot acceptance pulse; a transfer occurs when req_valid[i] and req_ready[i] are both 1.
REQ-009 SHALL have port rsp_valid  output  N_REQ: per-requester result valid, held until consumed.
REQ-010 SHALL have port rsp_z  output  N_REQ*32: per-requester product, same packing.
REQ-011 SHALL have port rsp_ready  input  N_REQ: per-requester result consume.
REQ-012 SHALL have port mul_start  output  1: single-cycle start pulse to the shared multiplier driver.
REQ-013 SHALL have ports mul_a and mul_b  output  32 each: operands, held stable from the start pulse until completion.
REQ-014 SHALL have port mul_busy  input  1: driver busy.
REQ-015 SHALL have port mul_done  input  1: driver done, a level that stays 1 until the next start.
REQ-016 SHALL have port mul_z  input  32: driver result.
REQ-017 SHALL have port timeout_err  output  1: sticky error flag.
REQ-018 SHALL have port op_count  output  16: count of completed products.

Function
REQ-019 FSM SHALL have states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, DELIVER.
REQ-020 IDLE SHALL select the eligible requester found by a round-robin search starting at last_grant+1, wrapping from N_REQ-1 to 0. A requester is eligible when req_valid[i]=1 and rsp_valid[i]=0.
REQ-021 On selection, IDLE SHALL:
- pulse req_ready[i] for exactly that cycle;
- latch the operands into mul_a/mul_b;
- store i as the current grant;
- go to ISSUE.
REQ-022 With no eligible requester, IDLE SHALL remain in IDLE with req_ready all 0.
REQ-023 ISSUE SHALL assert mul_start for exactly one cycle and then go to WAIT_BUSY.
REQ-024 WAIT_BUSY SHALL go to WAIT_DONE when mul_busy=1. The stale done level from the previous operation SHALL be ignored in this state.
REQ-025 WAIT_DONE SHALL go to DELIVER when mul_done=1 and mul_busy=0. On that transition it SHALL:
- capture mul_z into rsp_z[grant];
- set rsp_valid[grant];
- increment op_count, wrapping at 16 bits.
REQ-026 DELIVER SHALL set last_grant to the current grant and return to IDLE, one cycle.
REQ-027 Minimum accept-to-accept spacing SHALL be 4 cycles plus the driver latency.
REQ-028 rsp_valid[i] SHALL clear the cycle after rsp_ready[i]=1. When consume and a new set for the same requester coincide, the set SHALL win.
REQ-029 A requester with rsp_valid=1 SHALL be skipped, so that other requesters proceed and no head-of-line blocking occurs.
REQ-030 A timeout counter SHALL run in WAIT_BUSY and WAIT_DONE. When it reaches TIMEOUT_CYC, the block SHALL:
- set timeout_err, which stays set until reset;
- deliver z=0x7FC00000 (quiet NaN) to the granted requester;
- proceed to DELIVER.
REQ-031 Operand values SHALL pass through unmodified; the block performs no arithmetic on them.

Reset
REQ-032 rst_n=0 SHALL asynchronously force:
- FSM to IDLE;
- last_grant to N_REQ-1, so requester 0 wins first;
- req_ready, rsp_valid, mul_start, timeout_err to 0;
- mul_a, mul_b, rsp_z, op_count to 0.
REQ-033 Reset during any non-IDLE state SHALL abandon the operation. No response SHALL be produced for it, and any in-flight request SHALL be re-presented by its requester.

Structure
REQ-034 State enum, NAN_QUIET constant and FP word width SHALL live in shared package fp_mul_arb_pkg.
REQ-035 The round-robin selection SHALL be a sub-module rr_pick with inputs eligible[N_REQ] and last_grant, and outputs found and idx, purely combinational. All sequencing SHALL stay in fp_mul_arbiter.

Verification
REQ-036 The bench SHALL model the multiplier driver as a behavioural model with programmable latency, preserving done-level semantics, and SHALL cover these scenarios:
- Requester 0 sends a=0x3FC00000, b=0x40000000 → rsp_z[0]=0x40400000, rsp_valid[0]=1, op_count=1.
- Requesters 0 and 2 valid in the same cycle after reset → grant order 0 then 2; a following request from 0 is served after 2.
- All 4 requesters continuously valid, rsp_ready=1 → grant sequence 0,1,2,3,0,1.
- rsp_ready[1]=0 holds requester 1's result → requester 1 is never re-granted while 0, 2, 3 continue; after rsp_ready[1]=1, requester 1 is served next in turn.
- Model never asserts mul_busy → after 64 cycles timeout_err=1 and rsp_z=0x7FC00000 to the granted requester; the next request completes normally.
- rst_n pulsed low during WAIT_DONE → all outputs 0 immediately; the next request from requester 3 completes correctly.
